// File: rtl/irq_controller_if.sv
// irq_controller_if
//   Groups the core-facing interrupt handshake and the software register
//   window of irq_controller into one bundle.
//   Handshake : irq_req, irq_id, irq_vec (controller -> core)
//               irq_ack, irq_ret         (core -> controller, one-cycle pulses)
//   Registers : reg_we, reg_addr, reg_wdata (bus -> controller)
//               reg_rdata                   (controller -> bus, registered)
//   Modports  : slave  = the controller, master = the core / bus side.
interface irq_controller_if #(
   parameter int VEC_W = 16
);
   logic             irq_req;
   logic [2:0]       irq_id;
   logic [VEC_W-1:0] irq_vec;
   logic             irq_ack;
   logic             irq_ret;
   logic             reg_we;
   logic [2:0]       reg_addr;
   logic [7:0]       reg_wdata;
   logic [7:0]       reg_rdata;

   modport slave (
      output irq_req, irq_id, irq_vec, reg_rdata,
      input  irq_ack, irq_ret, reg_we, reg_addr, reg_wdata
   );

   modport master (
      input  irq_req, irq_id, irq_vec, reg_rdata,
      output irq_ack, irq_ret, reg_we, reg_addr, reg_wdata
   );
endinterface

// File: rtl/irq_controller.sv
// irq_controller
//   Collects NUM_SRC request lines (edge or level sensitive, maskable,
//   software-forceable), picks the lowest-index pending+enabled line and
//   presents it to the core as a vectored request with a req/ack/ret
//   handshake. No nesting: one interrupt in service at a time.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     src         : raw request lines, already synchronous to clk
//     user_mode   : interrupts are only taken while the core is in user mode
//     bus         : irq_controller_if.slave (handshake + register window)
//   Register map (reg_addr):
//     0 PEND (W1C on edge-mode bits), 1 MASK, 2 EDGE (1 = rising edge),
//     3 FORCE (W1S, reads 0), 4 ACTIVE (ro), 5 VBASE[7:0],
//     6 VBASE[VEC_W-1:8], 7 reads 0.
//   VEC_W is expected in 9..16 so that VBASE fits in the two byte registers.
module irq_controller #(
   parameter int NUM_SRC = 8,
   parameter int VEC_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src,
   input  logic               user_mode,
   irq_controller_if.slave    bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

   state_t             state_q;
   logic               irq_req_q;
   logic [2:0]         irq_id_q;
   logic [VEC_W-1:0]   irq_vec_q;

   logic [NUM_SRC-1:0] src_q, src_d;
   logic [NUM_SRC-1:0] lat_q, lat_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] edge_q, edge_d;
   logic [NUM_SRC-1:0] active_q, active_d;
   logic [VEC_W-1:0]   vbase_q, vbase_d;
   logic [7:0]         rdata_q, rdata_d;

   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] id_oh;
   logic [NUM_SRC-1:0] wdata_src;
   logic [15:0]        vbase_ext;
   logic               cand_found;
   logic [2:0]         cand_id;
   logic               ack_take;
   logic               ret_take;
   logic               withdraw;
   logic               wr_pend, wr_force;

   function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] base,
                                                input logic [2:0]       id);
      return base + VEC_W'({id, 2'b00});
   endfunction

   // lat_q holds captured edges for edge-mode lines and the software-forced
   // bit for level-mode lines, so a level line is pending while its sampled
   // input is high or it has been forced.
   assign pend      = lat_q | (src_q & ~edge_q);
   assign id_oh     = NUM_SRC'(1) << irq_id_q;
   assign wdata_src = bus.reg_wdata[NUM_SRC-1:0];
   assign vbase_ext = 16'(vbase_q);
   assign ack_take  = (state_q == S_REQ) && bus.irq_ack;
   assign ret_take  = (state_q == S_SERVICE) && bus.irq_ret;
   assign withdraw  = ~(|(id_oh & pend & mask_q)) || !user_mode;
   assign wr_pend   = bus.reg_we && (bus.reg_addr == 3'd0);
   assign wr_force  = bus.reg_we && (bus.reg_addr == 3'd3);

   // Fixed priority: lowest index wins, so scan downwards and keep the last hit.
   always_comb begin
      cand_found = 1'b0;
      cand_id    = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend[i] && mask_q[i]) begin
            cand_found = 1'b1;
            cand_id    = 3'(i);
         end
      end
   end

   always_comb begin
      src_d    = src;
      mask_d   = mask_q;
      edge_d   = edge_q;
      vbase_d  = vbase_q;
      active_d = active_q;
      rdata_d  = 8'h00;

      // Clears first, then sets, so a new edge or a force beats a W1C or ack
      // hitting the same bit in the same cycle.
      lat_d = lat_q;
      if (wr_pend)  lat_d = lat_d & ~(wdata_src & edge_q);
      if (ack_take) lat_d = lat_d & ~id_oh;
      lat_d = lat_d | (src & ~src_q & edge_q);
      if (wr_force) lat_d = lat_d | wdata_src;

      if (bus.reg_we) begin
         case (bus.reg_addr)
            3'd1:    mask_d = wdata_src;
            3'd2:    edge_d = wdata_src;
            3'd5:    vbase_d[7:0] = bus.reg_wdata;
            3'd6:    vbase_d[VEC_W-1:8] = bus.reg_wdata[VEC_W-9:0];
            default: ;
         endcase
      end

      if (ack_take)      active_d = id_oh;
      else if (ret_take) active_d = '0;

      case (bus.reg_addr)
         3'd0:    rdata_d = 8'(pend);
         3'd1:    rdata_d = 8'(mask_q);
         3'd2:    rdata_d = 8'(edge_q);
         3'd4:    rdata_d = 8'(active_q);
         3'd5:    rdata_d = vbase_ext[7:0];
         3'd6:    rdata_d = vbase_ext[15:8];
         default: rdata_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_q    <= '0;
         lat_q    <= '0;
         mask_q   <= '0;
         edge_q   <= '1;
         active_q <= '0;
         vbase_q  <= '0;
         rdata_q  <= '0;
      end else begin
         src_q    <= src_d;
         lat_q    <= lat_d;
         mask_q   <= mask_d;
         edge_q   <= edge_d;
         active_q <= active_d;
         vbase_q  <= vbase_d;
         rdata_q  <= rdata_d;
      end
   end

   // Request FSM. id and vector are latched on entry to REQ and held until
   // the next request, so later VBASE writes or higher-priority arrivals do
   // not disturb a request already presented to the core.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         irq_req_q <= 1'b0;
         irq_id_q  <= '0;
         irq_vec_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cand_found && user_mode && (active_q == '0)) begin
                  state_q   <= S_REQ;
                  irq_req_q <= 1'b1;
                  irq_id_q  <= cand_id;
                  irq_vec_q <= vec_of(vbase_q, cand_id);
               end
            end
            S_REQ: begin
               // ack has priority over a simultaneous withdraw condition
               if (bus.irq_ack) begin
                  state_q   <= S_SERVICE;
                  irq_req_q <= 1'b0;
               end else if (withdraw) begin
                  state_q   <= S_IDLE;
                  irq_req_q <= 1'b0;
               end
            end
            S_SERVICE: begin
               if (bus.irq_ret) state_q <= S_IDLE;
            end
            default: begin
               state_q   <= S_IDLE;
               irq_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.irq_req   = irq_req_q;
   assign bus.irq_id    = irq_id_q;
   assign bus.irq_vec   = irq_vec_q;
   assign bus.reg_rdata = rdata_q;

endmodule
